// File: rtl/pkt_rr_arb_if.sv
// Handshake bundle between the router input side and one pkt_rr_arb output port.
// The master side owns the requests and credit returns; the slave side (arbiter)
// owns grant, credit state and status.
// Build option: ARB_STAT_EN adds the per-port packet grant counters (gcnt).
interface pkt_rr_arb_if #(
   parameter int NPORT = 5,
   parameter int CW    = 3
);
   logic [NPORT-1:0] req;
   logic [NPORT-1:0] req_head;
   logic [NPORT-1:0] req_tail;
   logic             credit_in;
   logic [NPORT-1:0] grt;
   logic             fwd;
   logic [CW-1:0]    credit;
   logic             locked;
   logic             cred_err;
`ifdef ARB_STAT_EN
   logic [16*NPORT-1:0] gcnt;

   modport master (
      output req, req_head, req_tail, credit_in,
      input  grt, fwd, credit, locked, cred_err, gcnt
   );
   modport slave (
      input  req, req_head, req_tail, credit_in,
      output grt, fwd, credit, locked, cred_err, gcnt
   );
`else
   modport master (
      output req, req_head, req_tail, credit_in,
      input  grt, fwd, credit, locked, cred_err
   );
   modport slave (
      input  req, req_head, req_tail, credit_in,
      output grt, fwd, credit, locked, cred_err
   );
`endif
endinterface

// File: rtl/pkt_rr_arb.sv
// Per-output-port packet arbiter: round-robin among head flits, then holds the
// output for the winning input until its tail flit crosses. Every transfer is
// gated on downstream credit; the grant is combinational so a flit moves in the
// same cycle it is granted.
// Build option: ARB_STAT_EN adds saturating 16-bit packet counters per port.
module pkt_rr_arb #(
   parameter int NPORT = 5,
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic          clk,
   input  logic          rst_,
   pkt_rr_arb_if.slave   bus
);
   localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

   typedef enum logic {IDLE, LOCK} state_t;

   state_t           r_state;
   logic [PW-1:0]    r_ptr;
   logic [PW-1:0]    r_owner;
   logic [CW-1:0]    r_credit;
   logic             r_cred_err;

   logic [NPORT-1:0] w_elig;
   logic [NPORT-1:0] w_grt;
   logic [PW-1:0]    w_cand [NPORT];
   logic [PW-1:0]    w_win;
   logic             w_any;
   logic             w_has_credit;
   logic             w_fwd;

   // Next port after v, wrapping NPORT-1 back to 0.
   function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] v);
      if (v == PW'(NPORT - 1))
         return '0;
      else
         return v + PW'(1);
   endfunction

   assign w_elig       = bus.req & bus.req_head;
   assign w_has_credit = (r_credit != '0);

   // Candidate k of the scan is port (ptr + k) mod NPORT.
   for (genvar gi = 0; gi < NPORT; gi++) begin : g_cand
      logic [PW:0] w_sum;
      assign w_sum       = {1'b0, r_ptr} + (PW+1)'(gi);
      assign w_cand[gi]  = (w_sum >= (PW+1)'(NPORT)) ? PW'(w_sum - (PW+1)'(NPORT))
                                                      : w_sum[PW-1:0];
   end

   // Pick the first eligible head starting at ptr; scanning backwards lets the
   // closest candidate overwrite the farther ones.
   always_comb begin
      w_win = '0;
      w_any = 1'b0;
      for (int k = NPORT - 1; k >= 0; k--) begin
         if (w_elig[w_cand[k]]) begin
            w_win = w_cand[k];
            w_any = 1'b1;
         end
      end
   end

   // Grant: round-robin winner in IDLE, only the owner in LOCK, nothing without credit.
   always_comb begin
      w_grt = '0;
      if (w_has_credit) begin
         if (r_state == IDLE) begin
            if (w_any)
               w_grt[w_win] = 1'b1;
         end else begin
            w_grt[r_owner] = bus.req[r_owner];
         end
      end
   end

   assign w_fwd = |w_grt;

   // Packet state: a head-only winner takes the lock; the pointer moves past a
   // port once its packet has completely crossed.
   always_ff @(posedge clk) begin
      if (rst_) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
      end else if (r_state == IDLE) begin
         if (w_fwd) begin
            if (bus.req_tail[w_win]) begin
               r_ptr <= inc_mod(w_win);
            end else begin
               r_state <= LOCK;
               r_owner <= w_win;
            end
         end
      end else begin
         if (w_fwd && bus.req_tail[r_owner]) begin
            r_state <= IDLE;
            r_ptr   <= inc_mod(r_owner);
         end
      end
   end

   // Downstream credit: spend on transfer, refill on credit_in, saturate at DEPTH
   // and remember any overflow attempt until reset.
   always_ff @(posedge clk) begin
      if (rst_) begin
         r_credit   <= CW'(DEPTH);
         r_cred_err <= 1'b0;
      end else if (w_fwd && !bus.credit_in) begin
         r_credit <= r_credit - CW'(1);
      end else if (bus.credit_in && !w_fwd) begin
         if (r_credit == CW'(DEPTH))
            r_cred_err <= 1'b1;
         else
            r_credit <= r_credit + CW'(1);
      end
   end

   assign bus.grt      = w_grt;
   assign bus.fwd      = w_fwd;
   assign bus.credit   = r_credit;
   assign bus.locked   = (r_state == LOCK);
   assign bus.cred_err = r_cred_err;

`ifdef ARB_STAT_EN
   logic [15:0]         r_gcnt [NPORT];
   logic [16*NPORT-1:0] w_gcnt;

   // Only IDLE grants are head transfers, so they count whole packets.
   for (genvar gi = 0; gi < NPORT; gi++) begin : g_stat
      always_ff @(posedge clk) begin
         if (rst_)
            r_gcnt[gi] <= '0;
         else if ((r_state == IDLE) && w_grt[gi] && (r_gcnt[gi] != 16'hFFFF))
            r_gcnt[gi] <= r_gcnt[gi] + 16'd1;
      end
   end

   // Flatten the counters onto the status bus.
   always_comb begin
      w_gcnt = '0;
      for (int k = 0; k < NPORT; k++)
         w_gcnt[16*k +: 16] = r_gcnt[k];
   end

   assign bus.gcnt = w_gcnt;
`endif
endmodule

// File: tb/tb_pkt_rr_arb.sv
// Bench for pkt_rr_arb: directed vector table, hand-written reset/lock and
// statistics sequences, then random traffic against a packet-level model.
module tb_pkt_rr_arb;
   localparam int N     = 5;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic clk = 1'b0;
   logic rst_ = 1'b0;
   always #5 clk = ~clk;

   pkt_rr_arb_if #(.NPORT(N), .CW(CW)) bus();

   pkt_rr_arb #(.NPORT(N), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         do_rst;
      logic [4:0] req;
      logic [4:0] head;
      logic [4:0] tail;
      logic       cin;
      logic [4:0] e_grt;
      logic [2:0] e_cred;
      logic       e_lock;
      logic       e_err;
   } vec_t;

   vec_t vecs[$];

   // Packet-level reference: who holds the output, where the round-robin
   // search starts, and how many downstream slots are free.
   int m_owner;
   int m_ptr;
   int m_credit;
   bit m_err;
   int m_gcnt[N];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic add(input bit r, input logic [4:0] q, input logic [4:0] h, input logic [4:0] t,
                      input logic c, input logic [4:0] g, input logic [2:0] cr,
                      input logic l, input logic e);
      vec_t v;
      v.do_rst = r; v.req = q; v.head = h; v.tail = t; v.cin = c;
      v.e_grt = g; v.e_cred = cr; v.e_lock = l; v.e_err = e;
      vecs.push_back(v);
   endtask

   task automatic model_reset();
      m_owner  = -1;
      m_ptr    = 0;
      m_credit = DEPTH;
      m_err    = 1'b0;
      for (int i = 0; i < N; i++) m_gcnt[i] = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_ = 1'b1;
      bus.req = '0; bus.req_head = '0; bus.req_tail = '0; bus.credit_in = 1'b0;
      @(negedge clk);
      rst_ = 1'b0;
      model_reset();
   endtask

   // One clock of traffic: drive, let the combinational grant settle, compare.
   task automatic cycle(input string name, input logic [4:0] r, input logic [4:0] h,
                        input logic [4:0] t, input logic c, input logic [4:0] eg,
                        input logic [2:0] ec, input logic el, input logic ee);
      @(negedge clk);
      bus.req = r; bus.req_head = h; bus.req_tail = t; bus.credit_in = c;
      #1;
      $display("%s req=%b head=%b tail=%b cin=%b grt=%b credit=%0d locked=%b err=%b",
               name, r, h, t, c, bus.grt, bus.credit, bus.locked, bus.cred_err);
      check(name, {5'b0, bus.grt, bus.fwd, bus.credit, bus.locked, bus.cred_err},
                  {5'b0, eg, |eg, ec, el, ee});
   endtask

   function automatic int model_grant(input logic [4:0] r, input logic [4:0] h);
      if (m_credit == 0) return -1;
      if (m_owner >= 0) return r[m_owner] ? m_owner : -1;
      for (int i = 0; i < N; i++) begin
         int p;
         p = (m_ptr + i) % N;
         if (r[p] && h[p]) return p;
      end
      return -1;
   endfunction

   task automatic model_step(input logic [4:0] t, input logic c, input int g);
      if (g >= 0) begin
         if (m_owner < 0) begin
            m_gcnt[g]++;
            if (t[g]) m_ptr = (g + 1) % N;
            else      m_owner = g;
         end else if (t[g]) begin
            m_owner = -1;
            m_ptr   = (g + 1) % N;
         end
      end
      if (g >= 0 && !c)
         m_credit--;
      else if (c && g < 0) begin
         if (m_credit == DEPTH) m_err = 1'b1;
         else                   m_credit++;
      end
   endtask

   initial begin
      logic [4:0] r, h, t, eg;
      logic       c;
      int         g;

      bus.req = '0; bus.req_head = '0; bus.req_tail = '0; bus.credit_in = 1'b0;
      model_reset();

      // Round-robin with pointer wrap between two single-flit packet sources.
      add(1, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 4, 0, 0);
      add(0, 5'b10100, 5'b10100, 5'b10100, 0, 5'b00100, 4, 0, 0);
      add(0, 5'b10100, 5'b10100, 5'b10100, 0, 5'b10000, 3, 0, 0);
      add(0, 5'b10100, 5'b10100, 5'b10100, 0, 5'b00100, 2, 0, 0);
      // Port1 three-flit packet holds the output against port3 heads; head bit
      // on the owner during LOCK is just a body flit.
      add(1, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 4, 0, 0);
      add(0, 5'b01010, 5'b01010, 5'b00000, 0, 5'b00010, 4, 0, 0);
      add(0, 5'b01010, 5'b01010, 5'b00000, 0, 5'b00010, 3, 1, 0);
      add(0, 5'b01010, 5'b01000, 5'b00010, 0, 5'b00010, 2, 1, 0);
      add(0, 5'b01000, 5'b01000, 5'b01000, 0, 5'b01000, 1, 0, 0);
      add(0, 5'b01000, 5'b01000, 5'b01000, 0, 5'b00000, 0, 0, 0);
      // Credit exhaustion, and a returned credit usable only one cycle later.
      add(1, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 4, 0, 0);
      add(0, 5'b00001, 5'b00001, 5'b00001, 0, 5'b00001, 4, 0, 0);
      add(0, 5'b00001, 5'b00001, 5'b00001, 0, 5'b00001, 3, 0, 0);
      add(0, 5'b00001, 5'b00001, 5'b00001, 0, 5'b00001, 2, 0, 0);
      add(0, 5'b00001, 5'b00001, 5'b00001, 0, 5'b00001, 1, 0, 0);
      add(0, 5'b00001, 5'b00001, 5'b00001, 0, 5'b00000, 0, 0, 0);
      add(0, 5'b00001, 5'b00001, 5'b00001, 1, 5'b00000, 0, 0, 0);
      add(0, 5'b00001, 5'b00001, 5'b00001, 0, 5'b00001, 1, 0, 0);
      add(0, 5'b00001, 5'b00001, 5'b00001, 0, 5'b00000, 0, 0, 0);
      // Simultaneous spend and refill, overflow flag, non-head flit in IDLE.
      add(1, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 4, 0, 0);
      add(0, 5'b00001, 5'b00001, 5'b00001, 0, 5'b00001, 4, 0, 0);
      add(0, 5'b00001, 5'b00001, 5'b00001, 0, 5'b00001, 3, 0, 0);
      add(0, 5'b00001, 5'b00001, 5'b00001, 1, 5'b00001, 2, 0, 0);
      add(0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 2, 0, 0);
      add(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 2, 0, 0);
      add(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 3, 0, 0);
      add(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 4, 0, 0);
      add(0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 4, 0, 1);
      add(0, 5'b00001, 5'b00001, 5'b00001, 0, 5'b00001, 4, 0, 1);
      add(0, 5'b00010, 5'b00000, 5'b00000, 0, 5'b00000, 3, 0, 1);

      foreach (vecs[i]) begin
         if (vecs[i].do_rst) do_reset();
         cycle("vec", vecs[i].req, vecs[i].head, vecs[i].tail, vecs[i].cin,
               vecs[i].e_grt, vecs[i].e_cred, vecs[i].e_lock, vecs[i].e_err);
      end

      // Reset in the middle of a port2 packet drops the lock and restores credit;
      // port4's head then wins from pointer 0 over port2's stranded body flit.
      do_reset();
      cycle("rst_lock", 5'b00100, 5'b00100, 5'b00000, 0, 5'b00100, 4, 0, 0);
      cycle("rst_lock", 5'b00100, 5'b00000, 5'b00000, 0, 5'b00100, 3, 1, 0);
      @(negedge clk);
      rst_ = 1'b1;
      @(negedge clk);
      rst_ = 1'b0;
      cycle("rst_lock", 5'b10100, 5'b10000, 5'b00000, 0, 5'b10000, 4, 0, 0);

`ifdef ARB_STAT_EN
      // Packet counters: three packets from port0 (one of them two flits), one from port4.
      do_reset();
      cycle("stat", 5'b00001, 5'b00001, 5'b00001, 1, 5'b00001, 4, 0, 0);
      cycle("stat", 5'b00001, 5'b00001, 5'b00001, 1, 5'b00001, 4, 0, 0);
      cycle("stat", 5'b10000, 5'b10000, 5'b10000, 1, 5'b10000, 4, 0, 0);
      cycle("stat", 5'b00001, 5'b00001, 5'b00000, 1, 5'b00001, 4, 0, 0);
      cycle("stat", 5'b00001, 5'b00000, 5'b00001, 1, 5'b00001, 4, 1, 0);
      #1;
      check("gcnt0", bus.gcnt[0 +: 16], 16'd3);
      check("gcnt1", bus.gcnt[16 +: 16], 16'd0);
      check("gcnt2", bus.gcnt[32 +: 16], 16'd0);
      check("gcnt3", bus.gcnt[48 +: 16], 16'd0);
      check("gcnt4", bus.gcnt[64 +: 16], 16'd1);
`endif

      // Random traffic against the packet-level model.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(99) == 0) do_reset();
         r  = 5'($urandom);
         h  = 5'($urandom);
         t  = 5'($urandom);
         c  = ($urandom_range(9) < 3);
         g  = model_grant(r, h);
         eg = (g >= 0) ? 5'(1 << g) : 5'b0;
         cycle("rand", r, h, t, c, eg, 3'(m_credit), (m_owner >= 0), m_err);
         model_step(t, c, g);
      end

`ifdef ARB_STAT_EN
      @(negedge clk);
      bus.req = '0; bus.credit_in = 1'b0;
      #1;
      for (int i = 0; i < N; i++)
         check("rand_gcnt", bus.gcnt[16*i +: 16], 16'(m_gcnt[i]));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
